// File: rtl/mem_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: word type, FSM state
// encoding and starve-counter constants.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam int         STARVE_W   = 4;
  localparam logic [3:0] STARVE_MAX = 4'd15;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the datapath request streams, the arbiter and the RAM port.
// master = datapath/RAM-model side, slave = arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Handshake: a requester raises iREN or dREN/dWEN with its address/data and
  // holds them all until its wait goes low for exactly one cycle, which is the
  // completing cycle. Lowering the enable early withdraws the request. On the
  // RAM side the enables stay up until ramready completes the access.
  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  iwait;
  logic  dwait;
  word_t iload;
  word_t dload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramready;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of data grants taken while an instruction request waits;
// flags when the instruction side must be served next.
module starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                inc,
  input  logic                clr,
  output logic                at_limit,
  output logic [STARVE_W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != STARVE_MAX)) begin
      count <= count + 4'd1;
    end
  end

  assign at_limit = (count >= STARVE_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter, data-over-instruction priority, one access at a time.
// Optional instruction fairness compiled in with MEMARB_FAIRNESS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  mem_arbiter_if.slave        bus,
  output arb_state_t          dbg_state,
  output logic [STARVE_W-1:0] dbg_starve
);

  arb_state_t state;
  arb_state_t next_state;
  logic       d_req;
  logic       fair_ovr;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
  end

  assign d_req     = bus.dREN | bus.dWEN;
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_req && !fair_ovr) next_state = DACC;
        else if (bus.iREN)      next_state = IACC;
      end
      // A withdrawn enable aborts the access even if the RAM answers this cycle.
      IACC: begin
        if (!bus.iREN)         next_state = IDLE;
        else if (bus.ramready) next_state = DONE;
      end
      DACC: begin
        if (!d_req)            next_state = IDLE;
        else if (bus.ramready) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (nRST) begin
      case (state)
        IACC: begin
          if (bus.iREN) begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr;
            if (bus.ramready) begin
              bus.iwait = 1'b0;
              bus.iload = bus.ramload;
            end
          end
        end
        DACC: begin
          if (d_req) begin
            bus.ramaddr = bus.daddr;
            // A simultaneous read and write request is serviced as the write.
            if (bus.dWEN) begin
              bus.ramWEN   = 1'b1;
              bus.ramstore = bus.dstore;
            end else begin
              bus.ramREN = 1'b1;
            end
            if (bus.ramready) begin
              bus.dwait = 1'b0;
              if (!bus.dWEN) bus.dload = bus.ramload;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEMARB_FAIRNESS_EN
  logic starve_inc;
  logic starve_clr;
  logic starve_hit;

  assign starve_inc = (state == IDLE) && (next_state == DACC) && bus.iREN;
  assign starve_clr = (state == IDLE) && ((next_state == IACC) || !bus.iREN);
  assign fair_ovr   = starve_hit & bus.iREN;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .CLK      (CLK),
    .nRST     (nRST),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_hit),
    .count    (dbg_starve)
  );
`else
  assign fair_ovr   = 1'b0;
  assign dbg_starve = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model with a RAM model and expected-load queue.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIM = 2;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus_if();
  arb_state_t    dbg_state;
  logic [3:0]    dbg_starve;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus_if),
    .dbg_state  (dbg_state),
    .dbg_starve (dbg_starve)
  );

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  word_t ram_mem[word_t];
  word_t ref_mem[word_t];

  // requester, RAM model and reference-model state
  bit         i_pend, d_pend, i_done, d_done;
  int         rate_i, rate_d, lat_max;
  bit         ram_active;
  int         ram_cnt;
  int         m_busy, m_next, m_hold, m_starve;
  int         grants[$];
  arb_state_t prev_state;

  function automatic word_t init_word(word_t a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic word_t ram_rd(word_t a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic word_t ref_rd(word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.iREN = 1'b0; bus_if.iaddr = '0;
    bus_if.dREN = 1'b0; bus_if.dWEN = 1'b0;
    bus_if.daddr = '0;  bus_if.dstore = '0;
    bus_if.ramready = 1'b0; bus_if.ramload = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    bus_if.iREN = 1'b1; bus_if.dREN = 1'b1; bus_if.dWEN = 1'b1;
    bus_if.iaddr = 32'h40; bus_if.daddr = 32'h100; bus_if.dstore = 32'h1234;
    repeat (2) tick();
    #1;
    checks++;
    if ({bus_if.iwait, bus_if.dwait, bus_if.ramREN, bus_if.ramWEN} !== 4'b1100) begin
      errors++; $display("FAIL reset_ctrl got %b want 1100", {bus_if.iwait, bus_if.dwait, bus_if.ramREN, bus_if.ramWEN});
    end
    checks++;
    if ({bus_if.ramaddr, bus_if.ramstore, bus_if.iload, bus_if.dload} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", bus_if.ramaddr, bus_if.ramstore, bus_if.iload, bus_if.dload);
    end
    checks++;
    if (dbg_state !== IDLE || dbg_starve !== 4'd0) begin
      errors++; $display("FAIL reset_state got %0d/%0d want IDLE/0", dbg_state, dbg_starve);
    end
    tick(); nRST = 1'b1; #1;
    checks++;
    if ({bus_if.ramREN, bus_if.ramWEN} !== 2'b00) begin
      errors++; $display("FAIL release_idle got %b want 00", {bus_if.ramREN, bus_if.ramWEN});
    end
    tick(); #1;
    checks++;
    if (dbg_state !== DACC || {bus_if.ramREN, bus_if.ramWEN} !== 2'b01 ||
        bus_if.ramaddr !== 32'h100 || bus_if.ramstore !== 32'h1234) begin
      errors++; $display("FAIL release_dacc got st=%0d en=%b addr=%h st=%h want DACC 01 100 1234",
                         dbg_state, {bus_if.ramREN, bus_if.ramWEN}, bus_if.ramaddr, bus_if.ramstore);
    end
    clear_inputs(); #1;
    tick(); tick();
  endtask

  task automatic test_ifetch();
    bus_if.iREN = 1'b1; bus_if.iaddr = 32'h40; #1;
    checks++;
    if (bus_if.ramREN !== 1'b0) begin errors++; $display("FAIL if_idle ramREN got %b want 0", bus_if.ramREN); end
    tick(); #1;
    checks++;
    if (dbg_state !== IACC || bus_if.ramREN !== 1'b1 || bus_if.ramaddr !== 32'h40 || bus_if.iwait !== 1'b1) begin
      errors++; $display("FAIL if_iacc got st=%0d ren=%b addr=%h iwait=%b want IACC 1 40 1",
                         dbg_state, bus_if.ramREN, bus_if.ramaddr, bus_if.iwait);
    end
    tick(); bus_if.ramload = 32'h5555_AAAA; #1;
    checks++;
    if (bus_if.iwait !== 1'b1 || bus_if.iload !== 32'h0) begin
      errors++; $display("FAIL if_wait got iwait=%b iload=%h want 1 0", bus_if.iwait, bus_if.iload);
    end
    tick(); bus_if.ramready = 1'b1; bus_if.ramload = 32'h8C010004; #1;
    checks++;
    if ({bus_if.iwait, bus_if.dwait} !== 2'b01 || bus_if.iload !== 32'h8C010004 || bus_if.dload !== 32'h0) begin
      errors++; $display("FAIL if_done got waits=%b iload=%h dload=%h want 01 8c010004 0",
                         {bus_if.iwait, bus_if.dwait}, bus_if.iload, bus_if.dload);
    end
    tick(); bus_if.ramready = 1'b0; bus_if.iREN = 1'b0; bus_if.ramload = $urandom; #1;
    checks++;
    if (dbg_state !== DONE || bus_if.iwait !== 1'b1 || bus_if.iload !== 32'h0 || bus_if.ramREN !== 1'b0) begin
      errors++; $display("FAIL if_bubble got st=%0d iwait=%b iload=%h ren=%b want DONE 1 0 0",
                         dbg_state, bus_if.iwait, bus_if.iload, bus_if.ramREN);
    end
    tick(); #1;
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL if_back_idle got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_write_priority();
    bus_if.iREN = 1'b1; bus_if.iaddr = 32'h80;
    bus_if.dWEN = 1'b1; bus_if.daddr = 32'h100; bus_if.dstore = 32'hDEADBEEF;
    tick(); #1;
    checks++;
    if ({bus_if.ramREN, bus_if.ramWEN} !== 2'b01 || bus_if.ramaddr !== 32'h100 || bus_if.ramstore !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wp_write got en=%b addr=%h st=%h want 01 100 deadbeef",
                         {bus_if.ramREN, bus_if.ramWEN}, bus_if.ramaddr, bus_if.ramstore);
    end
    tick(); bus_if.ramready = 1'b1; bus_if.ramload = 32'h11112222; #1;
    checks++;
    if ({bus_if.iwait, bus_if.dwait} !== 2'b10 || bus_if.dload !== 32'h0) begin
      errors++; $display("FAIL wp_done got waits=%b dload=%h want 10 0", {bus_if.iwait, bus_if.dwait}, bus_if.dload);
    end
    tick(); bus_if.ramready = 1'b0; bus_if.dWEN = 1'b0; #1;
    checks++;
    if (dbg_state !== DONE || {bus_if.ramREN, bus_if.ramWEN} !== 2'b00) begin
      errors++; $display("FAIL wp_bubble got st=%0d en=%b want DONE 00", dbg_state, {bus_if.ramREN, bus_if.ramWEN});
    end
    tick(); tick(); #1;
    checks++;
    if (dbg_state !== IACC || bus_if.ramREN !== 1'b1 || bus_if.ramaddr !== 32'h80) begin
      errors++; $display("FAIL wp_ifetch got st=%0d ren=%b addr=%h want IACC 1 80", dbg_state, bus_if.ramREN, bus_if.ramaddr);
    end
    tick(); bus_if.ramready = 1'b1; bus_if.ramload = 32'hCAFE0001; #1;
    checks++;
    if (bus_if.iwait !== 1'b0 || bus_if.iload !== 32'hCAFE0001) begin
      errors++; $display("FAIL wp_idone got iwait=%b iload=%h want 0 cafe0001", bus_if.iwait, bus_if.iload);
    end
    tick(); clear_inputs(); tick();
  endtask

  task automatic test_abort();
    bus_if.dREN = 1'b1; bus_if.daddr = 32'h200;
    tick(); #1;
    checks++;
    if (dbg_state !== DACC || bus_if.ramREN !== 1'b1 || bus_if.ramaddr !== 32'h200) begin
      errors++; $display("FAIL ab_dacc got st=%0d ren=%b addr=%h want DACC 1 200", dbg_state, bus_if.ramREN, bus_if.ramaddr);
    end
    tick(); bus_if.dREN = 1'b0; #1;
    checks++;
    if ({bus_if.ramREN, bus_if.ramWEN, bus_if.dwait} !== 3'b001) begin
      errors++; $display("FAIL ab_drop got ren/wen/dwait=%b want 001", {bus_if.ramREN, bus_if.ramWEN, bus_if.dwait});
    end
    tick(); #1;
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL ab_idle got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_reset_mid();
    bus_if.iREN = 1'b1; bus_if.iaddr = 32'h300;
    tick(); #1;
    checks++;
    if (dbg_state !== IACC) begin errors++; $display("FAIL rm_iacc got %0d want IACC", dbg_state); end
    tick(); nRST = 1'b0;
    tick(); #1;
    checks++;
    if (dbg_state !== IDLE || bus_if.ramREN !== 1'b0 || dbg_starve !== 4'd0) begin
      errors++; $display("FAIL rm_reset got st=%0d ren=%b starve=%0d want IDLE 0 0", dbg_state, bus_if.ramREN, dbg_starve);
    end
    nRST = 1'b1; bus_if.iREN = 1'b0;
    tick(); tick();
  endtask

  // one cycle of requesters, RAM model and transaction-level reference
  task automatic run_engine(input int ncycles);
    logic  e_ren, e_wen, e_iw, e_dw, ovr;
    word_t e_addr, e_store, e_il, e_dl;
    int    k;
    for (int c = 0; c < ncycles; c++) begin
      tick();
      if (i_done) begin i_pend = 0; i_done = 0; bus_if.iREN = 1'b0; end
      if (d_done) begin d_pend = 0; d_done = 0; bus_if.dREN = 1'b0; bus_if.dWEN = 1'b0; end
      if (!i_pend && $urandom_range(0, 99) < rate_i) begin
        i_pend = 1; bus_if.iREN = 1'b1; bus_if.iaddr = 32'($urandom_range(0, 7)) << 2;
      end
      if (!d_pend && $urandom_range(0, 99) < rate_d) begin
        d_pend = 1; k = $urandom_range(0, 2);
        bus_if.dREN = (k != 1); bus_if.dWEN = (k != 0);
        bus_if.daddr = 32'($urandom_range(0, 7)) << 2; bus_if.dstore = $urandom;
      end
      #1;
      if (bus_if.ramREN || bus_if.ramWEN) begin
        if (!ram_active) begin
          ram_active = 1; ram_cnt = $urandom_range(1, lat_max); bus_if.ramready = 1'b0;
        end else begin
          ram_cnt--; bus_if.ramready = (ram_cnt == 0);
        end
      end else begin
        ram_active = 0; bus_if.ramready = 1'b0;
      end
      bus_if.ramload = (bus_if.ramready && bus_if.ramREN) ? ram_rd(bus_if.ramaddr) : $urandom;
      if (bus_if.ramready) ram_active = 0;
      #1;
      if (dbg_state != prev_state && (dbg_state == IACC || dbg_state == DACC))
        grants.push_back((dbg_state == IACC) ? 1 : 2);
      prev_state = dbg_state;

      if (m_next != 0) begin m_busy = m_next; m_next = 0; end
      e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_iw = 1; e_dw = 1; e_il = '0; e_dl = '0;
      if (m_busy == 1) begin
        e_ren = 1; e_addr = bus_if.iaddr;
        if (bus_if.ramready) begin
          e_iw = 0; e_il = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          m_busy = 0; m_hold = 1;
        end
      end else if (m_busy == 2) begin
        e_addr = bus_if.daddr;
        if (bus_if.dWEN) begin e_wen = 1; e_store = bus_if.dstore; end
        else e_ren = 1;
        if (bus_if.ramready) begin
          e_dw = 0;
          if (bus_if.dWEN) ref_mem[bus_if.daddr] = bus_if.dstore;
          else e_dl = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          m_busy = 0; m_hold = 1;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        ovr = 0;
`ifdef MEMARB_FAIRNESS_EN
        ovr = (m_starve >= LIM) && bus_if.iREN;
`endif
        if ((bus_if.dREN || bus_if.dWEN) && !ovr) begin
          m_next = 2;
          if (!bus_if.dWEN) exp_q.push_back(ref_rd(bus_if.daddr));
        end else if (bus_if.iREN) begin
          m_next = 1; exp_q.push_back(ref_rd(bus_if.iaddr));
        end
        if (m_next == 2 && bus_if.iREN) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        else if (m_next == 1 || !bus_if.iREN) m_starve = 0;
      end

      checks++;
      if ({bus_if.ramREN, bus_if.ramWEN, bus_if.ramaddr, bus_if.ramstore} !== {e_ren, e_wen, e_addr, e_store}) begin
        errors++;
        $display("FAIL cyc_ram t=%0t got en=%b addr=%h st=%h want en=%b addr=%h st=%h", $time,
                 {bus_if.ramREN, bus_if.ramWEN}, bus_if.ramaddr, bus_if.ramstore, {e_ren, e_wen}, e_addr, e_store);
      end
      checks++;
      if ({bus_if.iwait, bus_if.dwait, bus_if.iload, bus_if.dload} !== {e_iw, e_dw, e_il, e_dl}) begin
        errors++;
        $display("FAIL cyc_cpl t=%0t got waits=%b il=%h dl=%h want waits=%b il=%h dl=%h", $time,
                 {bus_if.iwait, bus_if.dwait}, bus_if.iload, bus_if.dload, {e_iw, e_dw}, e_il, e_dl);
      end
      if (bus_if.ramready && bus_if.ramWEN) ram_mem[bus_if.ramaddr] = bus_if.ramstore;
      if (bus_if.iwait === 1'b0) i_done = 1;
      if (bus_if.dwait === 1'b0) d_done = 1;
    end
  endtask

  task automatic drain();
    int n = 0;
    rate_i = 0; rate_d = 0;
    while ((i_pend || d_pend || m_busy != 0 || m_next != 0) && n < 200) begin
      run_engine(1); n++;
    end
    checks++;
    if (i_pend || d_pend || exp_q.size() != 0) begin
      errors++; $display("FAIL drain got pend=%b%b q=%0d want 00 0", i_pend, d_pend, exp_q.size());
    end
  endtask

  task automatic test_fairness();
    int exp_g[6];
    int n = 0;
`ifdef MEMARB_FAIRNESS_EN
    exp_g = '{2, 2, 1, 2, 2, 1};
`else
    exp_g = '{2, 2, 2, 2, 2, 2};
`endif
    rate_i = 100; rate_d = 100; lat_max = 1;
    grants.delete();
    while (grants.size() < 6 && n < 300) begin run_engine(1); n++; end
    checks++;
    if (grants.size() < 6) begin
      errors++; $display("FAIL fair_timeout got %0d grants want 6", grants.size());
    end else begin
      for (int g = 0; g < 6; g++) begin
        checks++;
        if (grants[g] !== exp_g[g]) begin
          errors++; $display("FAIL fair_grant%0d got %0d want %0d (1=I 2=D)", g, grants[g], exp_g[g]);
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    rate_i = 50; rate_d = 50; lat_max = 3;
    run_engine(400);
    drain();
  endtask

  initial begin
    clear_inputs();
    i_pend = 0; d_pend = 0; i_done = 0; d_done = 0; ram_active = 0; ram_cnt = 0;
    m_busy = 0; m_next = 0; m_hold = 0; m_starve = 0;
    test_reset();
    test_ifetch();
    test_write_priority();
    test_abort();
    test_reset_mid();
    clear_inputs();
    tick();
    prev_state = dbg_state;
    test_fairness();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
